// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Serial WIDTH-bit adder built on one shared 4-bit adder slice.
// It processes one nibble per clock, LSB nibble first, and keeps the
// carry between nibbles in a register.
// The host uses a start/busy/done handshake.
// Optional feature, selected by the macro SUB_MODE_EN: when it is
// defined, the block also subtracts (A - B computed as A + ~B + 1).
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SUB_MODE_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IW      = $clog2(NIBBLES + 1);

   // Reject widths that are not a whole number of nibbles, or are too narrow
   generate
      if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_cfg_err
         $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic             carry;
   logic [IW-1:0]    idx;
   logic             sub_r;

   logic [3:0]       an;
   logic [3:0]       bn;
   logic [4:0]       nsum;
   logic             init_carry;

`ifdef SUB_MODE_EN
   assign init_carry = sub;
`else
   assign init_carry = 1'b0;
`endif

   // Select the current nibble of each operand and run it through the 4-bit adder slice
   always_comb begin
      an = '0;
      bn = '0;
      for (int unsigned n = 0; n < NIBBLES; n++) begin
         if (idx == IW'(n)) begin
            an = areg[n*4 +: 4];
            bn = breg[n*4 +: 4];
         end
      end
      if (sub_r) begin
         bn = ~bn;
      end
      nsum = {1'b0, an} + {1'b0, bn} + {4'b0000, carry};
   end

   // Sequencer: state, operand copies, nibble index, carry and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         S     <= '0;
         Cout  <= 1'b0;
         areg  <= '0;
         breg  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sub_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  areg  <= A;
                  breg  <= B;
                  sub_r <= init_carry;
                  carry <= init_carry;
                  S     <= '0;
                  Cout  <= 1'b0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               for (int unsigned n = 0; n < NIBBLES; n++) begin
                  if (idx == IW'(n)) begin
                     S[n*4 +: 4] <= nsum[3:0];
                  end
               end
               carry <= nsum[4];
               idx   <= idx + 1'b1;
               if (idx == IW'(NIBBLES - 1)) begin
                  Cout  <= nsum[4];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl (WIDTH=16).
// Stimulus pushes the expected {Cout,S} into a queue; a monitor pops and
// compares on every done pulse. Build with SUB_MODE_EN to also cover subtraction.
`ifdef SUB_MODE_EN
`define SB(x) x,
`else
`define SB(x)
`endif

module tb_nibble_serial_add_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] S;
   logic        Cout;
`ifdef SUB_MODE_EN
   logic        sub;
`endif

   int n_cmp;
   int n_err;
   int n_done;
   logic [16:0] exp_q[$];

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
`ifdef SUB_MODE_EN
      .sub   (sub),
`endif
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .Cout  (Cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("sum_S", {16'h0, S}, {16'h0, e[15:0]});
            check("sum_Cout", {31'h0, Cout}, {31'h0, e[16]});
            check("busy_at_done", {31'h0, busy}, 32'd0);
         end
      end
   end

   // Issue one operation and check the handshake timing around it
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, `SB(input logic sb)
                         input logic [15:0] es, input logic ec);
      int  busy_n;
      bit  got;
      @(negedge clk);
      A = a;
      B = b;
`ifdef SUB_MODE_EN
      sub = sb;
`endif
      start = 1'b1;
      exp_q.push_back({ec, es});
      @(posedge clk);
      #1 start = 1'b0;
      busy_n = 0;
      got    = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (done) got = 1;
         else if (busy) busy_n++;
      end
      check("done_seen", {31'h0, got}, 32'd1);
      check("busy_cycles", busy_n, 32'd4);
      @(negedge clk);
      check("done_single", {31'h0, done}, 32'd0);
   endtask

   initial begin
      int d0;
      n_cmp  = 0;
      n_err  = 0;
      n_done = 0;
      rst_n  = 1'b0;
      start  = 1'b1;
      A      = 16'($urandom);
      B      = 16'($urandom);
`ifdef SUB_MODE_EN
      sub    = 1'b0;
`endif

      // Reset held with start asserted: outputs stay zero
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_outputs", {busy, done, Cout, 13'h0, S}, 32'd0);
         A = 16'($urandom);
         B = 16'($urandom);
      end
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_rst", {busy, done, Cout, 13'h0, S}, 32'd0);

      // Basic add plus partial-sum visibility
      @(negedge clk);
      A = 16'h1234; B = 16'h1111; start = 1'b1;
      exp_q.push_back({1'b0, 16'h2345});
      @(posedge clk);
      #1 start = 1'b0;
      check("partial_S_e0", {16'h0, S}, 32'h0000);
      @(posedge clk);
      #1 check("partial_S_e1", {16'h0, S}, 32'h0005);
      @(posedge clk);
      #1 check("partial_S_e2", {16'h0, S}, 32'h0045);
      repeat (4) @(negedge clk);
      check("S_hold_idle", {16'h0, S}, 32'h2345);

      // Carry ripple cases
      run_op(16'hFFFF, 16'h0001, `SB(1'b0) 16'h0000, 1'b1);
      run_op(16'h0FFF, 16'h0001, `SB(1'b0) 16'h1000, 1'b0);

      // Interference: start pulses and operand change while running
      d0 = n_done;
      @(negedge clk);
      A = 16'h00F0; B = 16'h0010; start = 1'b1;
      exp_q.push_back({1'b0, 16'h0100});
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      start = 1'b1; A = 16'hAAAA;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("interf_done_count", n_done - d0, 32'd1);
      check("interf_no_rerun", {31'h0, busy}, 32'd0);

      // Mid-run reset after the second nibble edge: immediate clear, no done
      d0 = n_done;
      @(negedge clk);
      A = 16'h1234; B = 16'h1111; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("midrst_outputs", {busy, done, Cout, 13'h0, S}, 32'd0);
      repeat (6) @(negedge clk);
      check("midrst_no_done", n_done - d0, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(16'h8000, 16'h8000, `SB(1'b0) 16'h0000, 1'b1);

`ifdef SUB_MODE_EN
      run_op(16'h0005, 16'h0007, `SB(1'b1) 16'hFFFE, 1'b0);
      run_op(16'h0007, 16'h0005, `SB(1'b1) 16'h0002, 1'b1);
      run_op(16'h1234, 16'h1111, `SB(1'b0) 16'h2345, 1'b0);
`endif

      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
